// File: rtl/avalon_pkg.sv
// Shared types and sizing helpers for the Avalon-ST packet source.
package avalon_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    localparam int DEF_MAX_LEN = 256;
    localparam int DEF_GAP_MAX = 15;

    // Width needed to hold any value 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST streaming link with readyLatency 0.
interface avalon_st_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  startofpacket;
    logic                  endofpacket;

    modport master (output valid, data, startofpacket, endofpacket, input ready);
    modport slave  (input valid, data, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/avalon_beat_cnt.sv
// Loadable up-counter; tc is high while the count equals the supplied terminal value.
module avalon_beat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/avalon_st_pkt_src.sv
// Avalon-ST packet transmitter: one start command emits LEN beats of an
// arithmetic payload sequence with sop/eop framing and optional inter-beat gaps.
module avalon_st_pkt_src
    import avalon_pkg::*;
#(
    parameter  int MAX_LEN = DEF_MAX_LEN,
    parameter  int GAP_MAX = DEF_GAP_MAX,
    localparam int LEN_W   = cnt_w(MAX_LEN),
    localparam int GAP_W   = cnt_w(GAP_MAX)
) (
    avalon_st_if.master                   msg_out,
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [LEN_W-1:0]              len,
    input  logic [msg_out.DATA_WIDTH-1:0] base,
    input  logic [msg_out.DATA_WIDTH-1:0] step,
    input  logic [GAP_W-1:0]              gap,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int DW = msg_out.DATA_WIDTH;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [DW-1:0]    step_q;
    logic [GAP_W-1:0] gap_q;
    logic [DW-1:0]    data_q;
    logic             valid_q;
    logic             sop_q;
    logic             eop_q;
    logic             eop_nxt_q;

    logic len_ok;
    logic accept;
    logic beat_adv;
    logic beat_nxt_last;
    logic gap_tc;

    assign len_ok   = (len != '0) && (len <= LEN_W'(MAX_LEN));
    assign accept   = (state == ST_SEND) && valid_q && msg_out.ready;
    assign beat_adv = accept && !eop_q;

    // Terminal value len-2 makes the flag mean "the beat after this one is the last".
    avalon_beat_cnt #(.W(LEN_W)) u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state == ST_IDLE) && start && len_ok),
        .load_val ('0),
        .inc      (beat_adv),
        .term     (len_q - LEN_W'(2)),
        .tc       (beat_nxt_last)
    );

    avalon_beat_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (beat_adv && (gap_q != '0)),
        .load_val ('0),
        .inc      (state == ST_GAP),
        .term     (gap_q - GAP_W'(1)),
        .tc       (gap_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            step_q    <= '0;
            gap_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            eop_nxt_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_q   <= len;
                            step_q  <= step;
                            gap_q   <= gap;
                            data_q  <= base;
                            valid_q <= 1'b1;
                            sop_q   <= 1'b1;
                            eop_q   <= (len == LEN_W'(1));
                            busy    <= 1'b1;
                            state   <= ST_SEND;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        sop_q <= 1'b0;
                        if (eop_q) begin
                            valid_q <= 1'b0;
                            eop_q   <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            data_q <= data_q + step_q;
                            if (gap_q != '0) begin
                                // Framing for the next beat is parked until the gap expires.
                                valid_q   <= 1'b0;
                                eop_q     <= 1'b0;
                                eop_nxt_q <= beat_nxt_last;
                                state     <= ST_GAP;
                            end else begin
                                eop_q <= beat_nxt_last;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_tc) begin
                        valid_q <= 1'b1;
                        eop_q   <= eop_nxt_q;
                        state   <= ST_SEND;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign msg_out.valid         = valid_q;
    assign msg_out.data          = data_q;
    assign msg_out.startofpacket = sop_q;
    assign msg_out.endofpacket   = eop_q;

endmodule

// File: tb/tb_avalon_st_pkt_src.sv
// Bench for avalon_st_pkt_src: table of packet commands plus hand-written corner sequences.
module tb_avalon_st_pkt_src;

    localparam int DW      = 8;
    localparam int MAX_LEN = 256;
    localparam int GAP_MAX = 15;
    localparam int LEN_W   = 9;
    localparam int GAP_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len   = '0;
    logic [DW-1:0]    base  = '0;
    logic [DW-1:0]    step  = '0;
    logic [GAP_W-1:0] gap   = '0;
    logic             busy;
    logic             done;
    logic             err;

    avalon_st_if #(.DATA_WIDTH(DW)) msg_if ();

    avalon_st_pkt_src #(.MAX_LEN(MAX_LEN), .GAP_MAX(GAP_MAX)) dut (
        .msg_out (msg_if),
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .len     (len),
        .base    (base),
        .step    (step),
        .gap     (gap),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct {
        int len;
        int base;
        int step;
        int gap;
        int rmode;
        bit exp_err;
    } vec_t;

    beat_t expq[$];
    vec_t  vecs[8];
    beat_t held;

    int nvec = 0, nmis = 0;
    int cyc = 0, last_acc = 0, acc_cnt = 0, done_cnt = 0, err_cnt = 0;
    int rmode = 0, stall_left = 0, exp_gap = 0, gap_run = 0;
    bit in_gap = 0, stall_prev = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive ready for the coming edge, then observe the DUT.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        cyc++;
        if (stall_left > 0) begin
            msg_if.ready = 1'b0;
            stall_left--;
        end else if (rmode == 1) begin
            msg_if.ready = ($urandom_range(0, 3) != 0);
        end else begin
            msg_if.ready = 1'b1;
        end
        if (!rst_n) begin
            stall_prev = 0;
            in_gap     = 0;
            return;
        end
        if (stall_prev) begin
            chk("hold_valid", int'(msg_if.valid), 1);
            chk("hold_data", int'(msg_if.data), int'(held.data));
            chk("hold_sop", int'(msg_if.startofpacket), int'(held.sop));
            chk("hold_eop", int'(msg_if.endofpacket), int'(held.eop));
        end
        if (in_gap) begin
            if (msg_if.valid) begin
                chk("gap_len", gap_run, exp_gap);
                in_gap = 0;
            end else begin
                gap_run++;
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_latency", cyc - last_acc, 1);
        end
        if (err) err_cnt++;
        stall_prev = msg_if.valid && !msg_if.ready;
        if (stall_prev) held = '{msg_if.data, msg_if.startofpacket, msg_if.endofpacket};
        if (msg_if.valid && msg_if.ready) begin
            acc_cnt++;
            last_acc = cyc;
            if (expq.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("beat_data", int'(msg_if.data), int'(e.data));
                chk("beat_sop", int'(msg_if.startofpacket), int'(e.sop));
                chk("beat_eop", int'(msg_if.endofpacket), int'(e.eop));
            end
            if (!msg_if.endofpacket) begin
                in_gap  = 1;
                gap_run = 0;
            end
        end
    endtask

    task automatic launch(input int l, input int b, input int s, input int g);
        len  = LEN_W'(l);
        base = DW'(b);
        step = DW'(s);
        gap  = GAP_W'(g);
        if (l >= 1 && l <= MAX_LEN) begin
            exp_gap = g;
            for (int i = 0; i < l; i++)
                expq.push_back('{DW'(b + i * s), (i == 0), (i == l - 1)});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < limit) begin
            tick();
            n++;
        end
        chk("done_seen", done_cnt - d0, 1);
    endtask

    initial begin
        int e0;
        vecs[0] = '{4,   'h10, 1,    0,  0, 0};
        vecs[1] = '{3,   'hFE, 1,    2,  0, 0};
        vecs[2] = '{1,   'h55, 3,    0,  0, 0};
        vecs[3] = '{0,   'h00, 0,    0,  0, 1};
        vecs[4] = '{5,   'h80, 'h7F, 1,  1, 0};
        vecs[5] = '{256, 'h00, 1,    0,  0, 0};
        vecs[6] = '{7,   'hF0, 'h11, 15, 1, 0};
        vecs[7] = '{300, 'h01, 1,    0,  0, 1};

        msg_if.ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", int'(msg_if.valid), 0);
        chk("rst_data", int'(msg_if.data), 0);
        chk("rst_sop", int'(msg_if.startofpacket), 0);
        chk("rst_eop", int'(msg_if.endofpacket), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
            rmode   = vecs[k].rmode;
            acc_cnt = 0;
            launch(vecs[k].len, vecs[k].base, vecs[k].step, vecs[k].gap);
            if (vecs[k].exp_err) begin
                chk("err_pulse", int'(err), 1);
                chk("err_busy", int'(busy), 0);
                tick();
                chk("err_clear", int'(err), 0);
                chk("err_idle_valid", int'(msg_if.valid), 0);
                chk("err_idle_busy", int'(busy), 0);
            end else begin
                chk("busy_rise", int'(busy), 1);
                chk("first_valid", int'(msg_if.valid), 1);
                wait_done(4000);
                chk("beat_count", acc_cnt, vecs[k].len);
                chk("queue_empty", expq.size(), 0);
                chk("busy_fall", int'(busy), 0);
                tick();
            end
        end
        rmode = 0;

        // Backpressure: beat 1 stalled for 5 cycles.
        acc_cnt = 0;
        launch(3, 'h20, 5, 0);
        stall_left = 5;
        wait_done(100);
        chk("bp_beats", acc_cnt, 3);
        chk("bp_queue", expq.size(), 0);
        tick();

        // Start while busy is ignored.
        acc_cnt = 0;
        e0 = err_cnt;
        launch(6, 'h40, 2, 1);
        tick();
        tick();
        len   = LEN_W'(2);
        base  = DW'('h99);
        step  = DW'(7);
        gap   = GAP_W'(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        chk("busy_start_err", err_cnt - e0, 0);
        chk("busy_start_beats", acc_cnt, 6);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_start_idle", int'(msg_if.valid), 0);
        end

        // Start in the done cycle launches the next packet at once.
        acc_cnt = 0;
        launch(2, 'h01, 1, 0);
        wait_done(50);
        launch(3, 'hA0, 'h10, 1);
        chk("b2b_valid", int'(msg_if.valid), 1);
        chk("b2b_sop", int'(msg_if.startofpacket), 1);
        wait_done(50);
        chk("b2b_beats", acc_cnt, 5);
        tick();

        // Reset asserted while beat 2 of 5 is on the bus.
        launch(5, 'h30, 1, 0);
        tick();
        tick();
        chk("pre_rst_valid", int'(msg_if.valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(msg_if.valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_sop", int'(msg_if.startofpacket), 0);
        chk("mid_rst_eop", int'(msg_if.endofpacket), 0);
        expq.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_valid", int'(msg_if.valid), 0);
            chk("post_rst_busy", int'(busy), 0);
        end
        acc_cnt = 0;
        launch(2, 'h77, 1, 0);
        wait_done(50);
        chk("post_rst_beats", acc_cnt, 2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
